// File: rtl/gray_to_binary_serial_pkg.sv
`default_nettype none
// ============================================================================
// Module      : gray_to_binary_serial_pkg
// Description : Shared definitions for the serial Gray-to-binary decoder:
//               FSM state encoding and default parameter values.
// Revision    : 1.0 - initial release
// ============================================================================
package gray_to_binary_serial_pkg;

    localparam int c_DEFAULT_WIDTH = 4;
    localparam int c_DEFAULT_CNT_W = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/gray_to_binary_serial_gray_bit_stage.sv
`default_nettype none
// ============================================================================
// Module      : gray_bit_stage
// Description : Resolves one binary bit from the next-higher binary bit and
//               the Gray bit at the same position: b[i] = b[i+1] ^ g[i].
//   i_b_hi : already-resolved binary bit b[i+1]
//   i_g    : Gray bit g[i]
//   o_b    : resolved binary bit b[i]
// Revision    : 1.0 - initial release
// ============================================================================
module gray_bit_stage (
    input  logic i_b_hi,
    input  logic i_g,
    output logic o_b
);

    assign o_b = i_b_hi ^ i_g;

endmodule
`default_nettype wire

// File: rtl/gray_to_binary_serial.sv
`default_nettype none
// ============================================================================
// Module      : gray_to_binary_serial
// Description : Serial Gray-to-binary decoder. Accepts one WIDTH-bit Gray
//               word on a valid/ready input handshake, resolves it MSB-first
//               one bit per clock, and presents the binary word on a
//               valid/ready output handshake. Counts completed conversions.
//   clk        : clock, rising edge
//   rst        : synchronous active-high reset
//   din        : Gray word, sampled on in_valid & in_ready
//   in_valid   : din valid
//   in_ready   : block can accept a word (IDLE only)
//   dout       : binary result, qualified by out_valid
//   out_valid  : dout holds a completed conversion
//   out_ready  : consumer accepts dout
//   busy       : conversion in flight (SHIFT or DONE)
//   conv_count : completed output handshakes, modulo 2^CNT_W
// Revision    : 1.0 - initial release
// ============================================================================
module gray_to_binary_serial
    import gray_to_binary_serial_pkg::*;
#(
    parameter int WIDTH = c_DEFAULT_WIDTH,
    parameter int CNT_W = c_DEFAULT_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] dout,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             busy,
    output logic [CNT_W-1:0] conv_count
);

    // Index must address bits 0..WIDTH-1 (idx+1 reaches WIDTH-1).
    localparam int c_IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [c_IDX_W-1:0] c_IDX_INIT = c_IDX_W'((WIDTH > 1) ? WIDTH - 2 : 0);

    state_t             r_state_q,     w_state_d;
    logic [c_IDX_W-1:0] r_idx_q,       w_idx_d;
    logic [WIDTH-1:0]   r_gray_q,      w_gray_d;
    logic [WIDTH-1:0]   r_dout_q,      w_dout_d;
    logic               r_out_valid_q, w_out_valid_d;
    logic [CNT_W-1:0]   r_count_q,     w_count_d;

    logic [c_IDX_W-1:0] w_idx_hi;
    logic               w_bit;

    assign w_idx_hi = r_idx_q + c_IDX_W'(1);

    // Single shared stage; its operands are selected by the current index.
    gray_bit_stage u_stage (
        .i_b_hi (r_dout_q[w_idx_hi]),
        .i_g    (r_gray_q[r_idx_q]),
        .o_b    (w_bit)
    );

    always_comb begin
        w_state_d     = r_state_q;
        w_idx_d       = r_idx_q;
        w_gray_d      = r_gray_q;
        w_dout_d      = r_dout_q;
        w_out_valid_d = r_out_valid_q;
        w_count_d     = r_count_q;

        case (r_state_q)
            IDLE: begin
                if (in_valid) begin
                    w_gray_d             = din;
                    w_dout_d             = '0;
                    // MSB of binary equals MSB of Gray.
                    w_dout_d[WIDTH-1]    = din[WIDTH-1];
                    w_idx_d              = c_IDX_INIT;
                    if (WIDTH == 1) begin
                        w_state_d     = DONE;
                        w_out_valid_d = 1'b1;
                    end else begin
                        w_state_d     = SHIFT;
                    end
                end
            end
            SHIFT: begin
                w_dout_d[r_idx_q] = w_bit;
                if (r_idx_q == '0) begin
                    w_state_d     = DONE;
                    w_out_valid_d = 1'b1;
                end else begin
                    w_idx_d = r_idx_q - c_IDX_W'(1);
                end
            end
            DONE: begin
                if (out_ready) begin
                    w_out_valid_d = 1'b0;
                    w_count_d     = r_count_q + CNT_W'(1);
                    w_state_d     = IDLE;
                end
            end
            default: begin
                w_state_d     = IDLE;
                w_out_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q     <= IDLE;
            r_idx_q       <= '0;
            r_gray_q      <= '0;
            r_dout_q      <= '0;
            r_out_valid_q <= 1'b0;
            r_count_q     <= '0;
        end else begin
            r_state_q     <= w_state_d;
            r_idx_q       <= w_idx_d;
            r_gray_q      <= w_gray_d;
            r_dout_q      <= w_dout_d;
            r_out_valid_q <= w_out_valid_d;
            r_count_q     <= w_count_d;
        end
    end

    assign in_ready   = (r_state_q == IDLE);
    assign busy       = (r_state_q != IDLE);
    assign dout       = r_dout_q;
    assign out_valid  = r_out_valid_q;
    assign conv_count = r_count_q;

endmodule
`default_nettype wire

// File: tb/tb_gray_to_binary_serial.sv
`default_nettype none
// ============================================================================
// Module      : tb_gray_to_binary_serial
// Description : Self-checking bench for gray_to_binary_serial. Two instances
//               share stimulus: default counter width and a 4-bit counter
//               to exercise wrap-around.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_gray_to_binary_serial;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic [W-1:0] din;
    logic         in_valid;
    logic         out_ready;

    logic         in_ready,  out_valid,  busy;
    logic [W-1:0] dout;
    logic [7:0]   conv_count;

    logic         in_ready2, out_valid2, busy2;
    logic [W-1:0] dout2;
    logic [3:0]   conv_count2;

    int checks = 0;
    int errors = 0;
    int model_cnt = 0;

    always #5 clk = ~clk;

    gray_to_binary_serial #(.WIDTH(W), .CNT_W(8)) u_dut (
        .clk(clk), .rst(rst), .din(din), .in_valid(in_valid),
        .in_ready(in_ready), .dout(dout), .out_valid(out_valid),
        .out_ready(out_ready), .busy(busy), .conv_count(conv_count)
    );

    gray_to_binary_serial #(.WIDTH(W), .CNT_W(4)) u_dut_wrap (
        .clk(clk), .rst(rst), .din(din), .in_valid(in_valid),
        .in_ready(in_ready2), .dout(dout2), .out_valid(out_valid2),
        .out_ready(out_ready), .busy(busy2), .conv_count(conv_count2)
    );

    // Reference binary-to-Gray encoder.
    function automatic logic [W-1:0] gray_enc(input logic [W-1:0] b);
        return b ^ (b >> 1);
    endfunction

    // Reference decoder: binary is the XOR of all right shifts of the Gray word.
    function automatic logic [W-1:0] gray_dec(input logic [W-1:0] g);
        logic [W-1:0] b;
        b = g;
        for (int s = 1; s < W; s++) b = b ^ (g >> s);
        return b;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_counts(input string tag);
        check({tag, "_cnt8"}, 32'(conv_count),  32'(model_cnt % 256));
        check({tag, "_cnt4"}, 32'(conv_count2), 32'(model_cnt % 16));
    endtask

    // Called at the first negedge after acceptance; returns cycles until out_valid.
    task automatic wait_out(output int lat);
        lat = 1;
        while (!out_valid && lat < 20) begin
            check("busy_in_flight", 32'(busy), 32'd1);
            check("in_ready_in_flight", 32'(in_ready), 32'd0);
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic do_conv(input logic [W-1:0] g, input int stall, input logic [W-1:0] exp_bin);
        int lat;
        logic [W-1:0] held;
        check("in_ready_idle", 32'(in_ready), 32'd1);
        din       = g;
        in_valid  = 1'b1;
        out_ready = (stall == 0);
        @(negedge clk);
        in_valid  = 1'b0;
        din       = W'($urandom);   // post-acceptance din changes must not matter
        wait_out(lat);
        check("latency", 32'(lat), 32'(W));
        check("dout", 32'(dout), 32'(exp_bin));
        check("dout_model", 32'(dout), 32'(gray_dec(g)));
        held = dout;
        for (int i = 0; i < stall; i++) begin
            in_valid = 1'b1;        // ignored while busy
            @(negedge clk);
            check("bp_valid", 32'(out_valid), 32'd1);
            check("bp_dout", 32'(dout), 32'(held));
            check("bp_in_ready", 32'(in_ready), 32'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        model_cnt++;
        check("post_hs_valid", 32'(out_valid), 32'd0);
        check("post_hs_in_ready", 32'(in_ready), 32'd1);
        check_counts("post_hs");
    endtask

    initial begin
        int lat;
        logic [W-1:0] g;

        rst = 1'b1; din = '0; in_valid = 1'b0; out_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_dout", 32'(dout), 32'd0);
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check_counts("rst");
        rst = 1'b0;
        @(negedge clk);

        // Basic conversion.
        do_conv(4'b0110, 0, 4'b0100);

        // Back-to-back with in_valid held high.
        din = 4'b1000; in_valid = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        din = 4'b0000;
        wait_out(lat);
        check("b2b1_latency", 32'(lat), 32'(W));
        check("b2b1_dout", 32'(dout), 32'hF);
        @(negedge clk);
        model_cnt++;
        check("b2b_gap_in_ready", 32'(in_ready), 32'd1);
        check_counts("b2b1");
        @(negedge clk);
        in_valid = 1'b0;
        wait_out(lat);
        check("b2b2_latency", 32'(lat), 32'(W));
        check("b2b2_dout", 32'(dout), 32'h0);
        @(negedge clk);
        model_cnt++;
        check_counts("b2b2");

        // Backpressure.
        do_conv(4'b1101, 6, 4'b1001);

        // Reset during the second SHIFT cycle.
        din = 4'b1111; in_valid = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        model_cnt = 0;
        check("rs_in_ready", 32'(in_ready), 32'd1);
        check("rs_valid", 32'(out_valid), 32'd0);
        check("rs_dout", 32'(dout), 32'd0);
        check_counts("rs");
        do_conv(4'b0001, 0, 4'b0001);

        // Reset while DONE and stalled.
        din = 4'b1010; in_valid = 1'b1; out_ready = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        wait_out(lat);
        check("rd_valid_before", 32'(out_valid), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0; out_ready = 1'b1;
        model_cnt = 0;
        check("rd_valid", 32'(out_valid), 32'd0);
        check("rd_busy", 32'(busy), 32'd0);
        check_counts("rd");

        // Exhaustive round trip through the encoder; also wraps the 4-bit counter.
        for (int v = 0; v < 16; v++) begin
            do_conv(gray_enc(W'(v)), int'($urandom_range(0, 2)), W'(v));
        end
        check("rt_cnt_after16", 32'(model_cnt), 32'd16);

        // Random words with random backpressure.
        for (int n = 0; n < 20; n++) begin
            g = W'($urandom);
            do_conv(g, int'($urandom_range(0, 3)), gray_dec(g));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/gray_to_binary_serial.md
Name: gray_to_binary_serial

Overview:
- Serial Gray-to-binary decoder. It is the receive-side counterpart of the lab's 4-bit binary-to-Gray encoder.
- Accepts one WIDTH-bit Gray word over a valid/ready handshake and resolves it MSB-first, one bit per clock (b[i] = b[i+1] XOR g[i]).
- Presents the binary word on a valid/ready output handshake.
- Keeps a wrap-around count of completed conversions for bench/board observation.

Parameters:
- WIDTH, 4, Gray/binary word width; legal range 1..16.
- CNT_W, 8, width of the completed-conversion counter.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- din  input  WIDTH  Gray-coded input word; sampled only on input handshake.
- in_valid  input  1  din is valid.
- in_ready  output  1  block can accept a word; high only in IDLE.
- dout  output  WIDTH  binary result; meaningful only while out_valid=1.
- out_valid  output  1  dout holds a completed conversion.
- out_ready  input  1  consumer accepts dout.
- busy  output  1  high in SHIFT or DONE.
- conv_count  output  CNT_W  number of completed output handshakes, modulo 2^CNT_W.

Behaviour:
- Reset: on the rising edge of clk with rst=1, state=IDLE, dout=0, out_valid=0, busy=0, conv_count=0, internal shift register and bit index=0. rst overrides every other input in the same cycle.
- State IDLE:
  - in_ready=1.
  - On in_valid&in_ready: capture din into the Gray shadow register; set dout[WIDTH-1]=din[WIDTH-1], clear the lower dout bits, set bit index=WIDTH-2.
  - Go to SHIFT. If WIDTH=1, go directly to DONE.
  - in_valid=0: stay in IDLE, no register changes.
- State SHIFT:
  - in_ready=0.
  - Each cycle: dout[idx] = dout[idx+1] XOR g[idx]; then decrement idx.
  - After computing bit 0, go to DONE.
  - SHIFT lasts exactly WIDTH-1 cycles.
- State DONE:
  - out_valid=1; dout is held stable.
  - On out_valid&out_ready: increment conv_count (wraps 2^CNT_W-1 -> 0), drop out_valid, go to IDLE.
  - out_ready low: hold indefinitely with no change to any output.
- Latency: the input handshake occurs at edge E. out_valid is first high in the cycle after edge E+WIDTH-1, i.e. WIDTH cycles after acceptance (4 for the default). WIDTH=1 gives 1 cycle.
- Throughput: one word per WIDTH+1 cycles minimum. There is no overlap; a new word can be accepted only in the cycle after the output handshake (IDLE).
- in_valid while busy: ignored, no side effects. din changes after acceptance do not affect the result.
- out_ready while not out_valid: ignored.
- Reset mid-SHIFT or mid-DONE: the in-flight word is discarded, no output handshake occurs, conv_count is cleared.
- Intermediate dout bits may be visible during SHIFT but are not qualified; only out_valid qualifies dout.
- All outputs are registered, except in_ready and busy, which are decoded directly from the state register.

Decomposition:
- Shared package holds the state encoding constants (IDLE=2'd0, SHIFT=2'd1, DONE=2'd2) and the default WIDTH.
- One natural sub-module: gray_bit_stage, a single-bit XOR resolving b[i] from b[i+1] and g[i]. It is instantiated once, with its inputs muxed by idx.
- FSM, index counter, output register and conv_count live in the top module.

Test Plan:
- WIDTH=4, din=4'b0110 with in_valid pulsed one cycle, out_ready=1 -> in_ready low for 4 cycles, then out_valid high for 1 cycle with dout=4'b0100, conv_count=1.
- din=4'b1000, then din=4'b0000 back-to-back with in_valid held high -> dout=4'b1111 then dout=4'b0000. The second word is accepted only after the first output handshake; conv_count=2.
- Backpressure: din=4'b1101, out_ready held low 6 cycles after out_valid rises -> dout=4'b1001 stable, out_valid stays high, in_ready=0 throughout; one handshake when out_ready rises.
- Reset mid-SHIFT: accept din=4'b1111, assert rst in the 2nd SHIFT cycle -> next cycle state IDLE, out_valid=0, dout=0, in_ready=1, conv_count=0. The next word 4'b0001 decodes to 4'b0001.
- Exhaustive round trip: feed all 16 binary values through the existing binary-to-Gray encoder into this block -> every dout equals the original value, 16 handshakes.
- Counter wrap with CNT_W=4: 17 conversions -> conv_count reads 15 after the 15th conversion, 0 after the 16th, 1 after the 17th.
